multicycle_ctrl: RTL and testbench

Finite-state controller that sequences a shared-memory multicycle MIPS datapath. It replaces the single-cycle decoder: one instruction takes 3–5 cycles, and a single memory port is time-shared between instruction fetch and data access. It decodes opcode/funct, drives every datapath select and write enable per state, and stalls on a memory-ready handshake. It supports lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.

---
 rtl/multicycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over a shared memory port.
// Moore outputs per state; FETCH/MEMRD/MEMWR stall on mem_ready, writes are gated while reset is held.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcen,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q, state_d;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic       pcwrite, branch;
    logic       irwrite_raw, memwrite_raw, regwrite_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        iord         = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        regwrite_raw = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        alucontrol   = ALU_AND;
        illegal      = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb     = 2'b01;
                alucontrol  = ALU_ADD;
                irwrite_raw = mem_ready;
                pcwrite     = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    OP_RTYPE: begin
                        state_d = funct_ok ? S_EXECUTE : S_FETCH;
                        illegal = ~funct_ok;
                    end
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_d    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            // Strobe is level-held for the whole dwell; the memory takes it on the ready cycle.
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_d    = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset is asynchronous, so state is already FETCH; also block every datapath load.
    assign irwrite  = irwrite_raw  & ~reset;
    assign memwrite = memwrite_raw & ~reset;
    assign regwrite = regwrite_raw & ~reset;
    assign pcen     = (pcwrite | (branch & zero)) & ~reset;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction streams with fetch/memory stalls checked against a per-instruction state-trace model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int tests = 0;
    int fails = 0;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            default:   return 3'b111;
        endcase
    endfunction

    function automatic bit op_supported(input logic [5:0] o);
        return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    function automatic bit funct_supported(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b101010, 6'b100101};
    endfunction

    // kind: 0 lw, 1 sw, 2..6 R add/sub/and/or/slt, 7 beq, 8 addi, 9 j, 10 illegal op, 11 illegal funct
    task automatic run_instr(input int kind, input int fs, input int ms, input int zmode);
        int          st_q[$];
        bit          rdy_q[$];
        logic [5:0]  o, f;
        logic [5:0]  rfuncts[5];
        int          n_rw, n_mw, n_ir, n_ill;
        logic [15:0] obs, exp;
        logic [1:0]  e_srcb, e_pcsrc;
        logic [2:0]  e_alu;
        logic        z;
        int          st;
        bit          rdy;

        rfuncts = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        f = 6'($urandom);
        case (kind)
            0:  o = 6'b100011;
            1:  o = 6'b101011;
            7:  o = 6'b000100;
            8:  o = 6'b001000;
            9:  o = 6'b000010;
            10: begin
                o = 6'b111111;
                if (fs != 0) while (op_supported(o)) o = 6'($urandom);
            end
            11: begin
                o = 6'b000000;
                f = 6'b000111;
                if (fs != 0) while (funct_supported(f)) f = 6'($urandom);
            end
            default: begin
                o = 6'b000000;
                f = rfuncts[kind-2];
            end
        endcase

        for (int i = 0; i < fs; i++) begin st_q.push_back(0); rdy_q.push_back(1'b0); end
        st_q.push_back(0); rdy_q.push_back(1'b1);
        st_q.push_back(1); rdy_q.push_back(1'($urandom));
        case (kind)
            0: begin
                st_q.push_back(2); rdy_q.push_back(1'($urandom));
                for (int i = 0; i < ms; i++) begin st_q.push_back(3); rdy_q.push_back(1'b0); end
                st_q.push_back(3); rdy_q.push_back(1'b1);
                st_q.push_back(4); rdy_q.push_back(1'($urandom));
            end
            1: begin
                st_q.push_back(2); rdy_q.push_back(1'($urandom));
                for (int i = 0; i < ms; i++) begin st_q.push_back(5); rdy_q.push_back(1'b0); end
                st_q.push_back(5); rdy_q.push_back(1'b1);
            end
            7: begin st_q.push_back(8); rdy_q.push_back(1'($urandom)); end
            8: begin
                st_q.push_back(9);  rdy_q.push_back(1'($urandom));
                st_q.push_back(10); rdy_q.push_back(1'($urandom));
            end
            9: begin st_q.push_back(11); rdy_q.push_back(1'($urandom)); end
            10, 11: ;
            default: begin
                st_q.push_back(6); rdy_q.push_back(1'($urandom));
                st_q.push_back(7); rdy_q.push_back(1'($urandom));
            end
        endcase

        n_rw = 0; n_mw = 0; n_ir = 0; n_ill = 0;
        for (int i = 0; i < st_q.size(); i++) begin
            @(negedge clk);
            st  = st_q[i];
            rdy = rdy_q[i];
            z   = (zmode == 2) ? 1'($urandom) : (zmode == 1);
            op = o; funct = f; mem_ready = rdy; zero = z;
            #1;
            check($sformatf("state k%0d c%0d", kind, i), 32'(state), 32'(st));
            e_srcb  = (st == 0) ? 2'b01 : (st == 1) ? 2'b11 : (st == 2 || st == 9) ? 2'b10 : 2'b00;
            e_pcsrc = (st == 8) ? 2'b01 : (st == 11) ? 2'b10 : 2'b00;
            e_alu   = (st inside {0, 1, 2, 9}) ? 3'b010 : (st == 8) ? 3'b110 :
                      (st == 6) ? alu_of_funct(f) : 3'b000;
            exp = {st inside {3, 5}, st == 5, st == 0 && rdy,
                   (st == 0 && rdy) || st == 11 || (st == 8 && z),
                   st == 7, st == 4, st inside {4, 7, 10}, st inside {2, 6, 8, 9},
                   e_srcb, e_pcsrc, e_alu, st == 1 && kind >= 10};
            obs = {iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca,
                   alusrcb, pcsrc, alucontrol, illegal};
            check($sformatf("ctrl k%0d s%0d", kind, st), 32'(obs), 32'(exp));
            n_rw  += int'(regwrite);
            n_mw  += int'(memwrite);
            n_ir  += int'(irwrite);
            n_ill += int'(illegal);
        end
        check($sformatf("regwr_cnt k%0d", kind), n_rw, (kind == 1 || kind == 7 || kind >= 9) ? 0 : 1);
        check($sformatf("memwr_cnt k%0d", kind), n_mw, (kind == 1) ? ms + 1 : 0);
        check($sformatf("irwr_cnt k%0d", kind), n_ir, 1);
        check($sformatf("illegal_cnt k%0d", kind), n_ill, (kind >= 10) ? 1 : 0);
    endtask

    initial begin
        reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b1; mem_ready = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ctrl",
              32'({iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca,
                   alusrcb, pcsrc, alucontrol, illegal}),
              32'({8'b0, 2'b01, 2'b00, 3'b010, 1'b0}));
        repeat (2) @(posedge clk);
        #1 check("rst_hold_state", 32'(state), 32'd0);
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0;

        for (int k = 0; k < 12; k++) run_instr(k, k % 3, (k == 1) ? 3 : k % 2, 2);
        run_instr(7, 0, 0, 1);
        run_instr(7, 0, 0, 0);

        // Abort a stalled lw in MEMRD: no MEMWB may follow.
        run_instr(9, 0, 0, 2);
        op = 6'b100011;
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check("abort_in_memrd", 32'(state), 32'd3);
        #2 reset = 1'b1; mem_ready = 1'b1;
        #1;
        check("abort_async_state", 32'(state), 32'd0);
        check("abort_gated", 32'({irwrite, pcen, regwrite, memwrite}), 32'd0);
        @(posedge clk);
        #1 check("abort_held", 32'({state, irwrite, pcen}), 32'd0);
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        #1 check("abort_no_memwb", 32'(state), 32'd0);

        for (int n = 0; n < 80; n++)
            run_instr(int'($urandom_range(0, 11)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
